// File: rtl/cvi_stream_rx.sv
// Clocked-video receiver: sync-based parallel video in, one Avalon-ST packet per frame out,
// plus per-frame active-resolution measurement and a sticky pixel-drop flag.
module cvi_stream_rx #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 12
) (
    input  logic              vid_clk_clk,
    input  logic              vid_reset_reset_n,
    input  logic [DATA_W-1:0] vid_data,
    input  logic              vid_datavalid,
    input  logic              vid_h_sync,
    input  logic              vid_v_sync,
    input  logic              vid_f,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              src_startofpacket,
    output logic              src_endofpacket,
    output logic [CNT_W-1:0]  frame_width,
    output logic [CNT_W-1:0]  frame_height,
    output logic              frame_field,
    output logic              frame_stat_valid,
    output logic              overflow,
    input  logic              overflow_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] LIM_TWO = AW'(FIFO_DEPTH - 3);
    localparam logic [AW-1:0] LIM_ONE = AW'(FIFO_DEPTH - 2);

    typedef enum logic {WAIT_VS, ACTIVE} state_t;

    state_t             r_state, w_state_next;
    logic [DATA_W-1:0]  r_data;
    logic               r_dv, r_hs, r_vs, r_f, r_hs_d, r_vs_d;
    logic               r_pend_valid, r_pend_sop, r_first;
    logic [DATA_W-1:0]  r_pend_data;
    logic [DATA_W+1:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]   r_lines, r_width;
    logic               r_line_arm, r_field;

    logic               w_capture, w_vs_edge, w_hs_edge, w_capture_active;
    logic [AW-1:0]      w_count;
    logic               w_room1, w_room2, w_empty, w_pop;
    logic               w_push, w_push_eop, w_pend_load, w_pend_clear, w_ovf_set, w_stat_update;
    logic               w_line_inc;
    logic [CNT_W-1:0]   w_lines_next;
    logic [DATA_W+1:0]  w_head;

    always_ff @(posedge vid_clk_clk or negedge vid_reset_reset_n) begin
        if (!vid_reset_reset_n) begin
            r_data <= '0;
            r_dv   <= 1'b0;
            r_hs   <= 1'b0;
            r_vs   <= 1'b0;
            r_f    <= 1'b0;
            r_hs_d <= 1'b0;
            r_vs_d <= 1'b0;
        end else begin
            r_data <= vid_data;
            r_dv   <= vid_datavalid;
            r_hs   <= vid_h_sync;
            r_vs   <= vid_v_sync;
            r_f    <= vid_f;
            r_hs_d <= r_hs;
            r_vs_d <= r_vs;
        end
    end

    assign w_capture        = r_dv & ~r_hs & ~r_vs;
    assign w_vs_edge        = r_vs & ~r_vs_d;
    assign w_hs_edge        = r_hs & ~r_hs_d;
    assign w_capture_active = w_capture & (r_state == ACTIVE);

    // One slot is never filled, so occupancy is simply the pointer difference.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_room2 = (w_count <= LIM_TWO);
    assign w_room1 = (w_count <= LIM_ONE);
    assign w_empty = (w_count == '0);
    assign w_pop   = ~w_empty & src_ready;

    always_ff @(posedge vid_clk_clk or negedge vid_reset_reset_n) begin
        if (!vid_reset_reset_n) r_state <= WAIT_VS;
        else                    r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_push        = 1'b0;
        w_push_eop    = 1'b0;
        w_pend_load   = 1'b0;
        w_pend_clear  = 1'b0;
        w_ovf_set     = 1'b0;
        w_stat_update = 1'b0;
        case (r_state)
            WAIT_VS: begin
                if (w_vs_edge) w_state_next = ACTIVE;
            end
            ACTIVE: begin
                if (w_vs_edge) begin
                    w_stat_update = (r_lines != '0) && (!r_pend_valid || w_room1);
                    if (r_pend_valid) begin
                        w_pend_clear = 1'b1;
                        if (w_room1) begin
                            w_push     = 1'b1;
                            w_push_eop = 1'b1;
                        end else begin
                            w_ovf_set    = 1'b1;
                            w_state_next = WAIT_VS;
                        end
                    end
                end else if (w_capture) begin
                    if (!r_pend_valid) begin
                        w_pend_load = 1'b1;
                    end else if (w_room2) begin
                        w_push      = 1'b1;
                        w_pend_load = 1'b1;
                    end else begin
                        // An unstarted packet is discarded; an open one is closed off.
                        w_pend_clear = 1'b1;
                        w_ovf_set    = 1'b1;
                        w_state_next = WAIT_VS;
                        if (!r_pend_sop && w_room1) begin
                            w_push     = 1'b1;
                            w_push_eop = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge vid_clk_clk or negedge vid_reset_reset_n) begin
        if (!vid_reset_reset_n) begin
            r_pend_valid <= 1'b0;
            r_pend_sop   <= 1'b0;
            r_pend_data  <= '0;
            r_first      <= 1'b0;
        end else begin
            if (w_pend_load) begin
                r_pend_valid <= 1'b1;
                r_pend_sop   <= r_first;
                r_pend_data  <= r_data;
            end else if (w_pend_clear) begin
                r_pend_valid <= 1'b0;
            end
            if (w_vs_edge)        r_first <= 1'b1;
            else if (w_pend_load) r_first <= 1'b0;
        end
    end

    always_ff @(posedge vid_clk_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {w_push_eop, r_pend_sop, r_pend_data};
    end

    always_ff @(posedge vid_clk_clk or negedge vid_reset_reset_n) begin
        if (!vid_reset_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        end
    end

    assign w_head            = r_mem[r_rd_ptr];
    assign src_valid         = ~w_empty;
    assign src_data          = src_valid ? w_head[DATA_W-1:0] : '0;
    assign src_startofpacket = src_valid & w_head[DATA_W];
    assign src_endofpacket   = src_valid & w_head[DATA_W+1];

    assign w_line_inc   = w_capture_active & r_line_arm;
    assign w_lines_next = (w_line_inc && r_lines != '1) ? r_lines + CNT_W'(1) : r_lines;

    // Width only grows while the line counter reads one, i.e. in the first active line.
    always_ff @(posedge vid_clk_clk or negedge vid_reset_reset_n) begin
        if (!vid_reset_reset_n) begin
            r_lines    <= '0;
            r_width    <= '0;
            r_line_arm <= 1'b0;
            r_field    <= 1'b0;
        end else if (w_vs_edge) begin
            r_lines    <= '0;
            r_width    <= '0;
            r_line_arm <= 1'b1;
        end else begin
            if (w_hs_edge) r_line_arm <= 1'b1;
            if (w_capture_active) begin
                r_line_arm <= 1'b0;
                r_lines    <= w_lines_next;
                if (w_lines_next == CNT_W'(1) && r_width != '1) r_width <= r_width + CNT_W'(1);
                if (r_lines == '0) r_field <= r_f;
            end
        end
    end

    always_ff @(posedge vid_clk_clk or negedge vid_reset_reset_n) begin
        if (!vid_reset_reset_n) begin
            frame_width      <= '0;
            frame_height     <= '0;
            frame_field      <= 1'b0;
            frame_stat_valid <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            frame_stat_valid <= w_stat_update;
            if (w_stat_update) begin
                frame_width  <= r_width;
                frame_height <= r_lines;
                frame_field  <= r_field;
            end
            if (w_ovf_set)         overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cvi_stream_rx.sv
// Directed bench for cvi_stream_rx: drives sync-based video frames and scoreboards the packet
// stream, the frame statistics and the overflow flag.
module tb_cvi_stream_rx;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 12;

    logic              clk = 1'b0;
    logic              rstN = 1'b0;
    logic [DATA_W-1:0] vidData = '0;
    logic              vidDv = 1'b0, vidHs = 1'b0, vidVs = 1'b0, vidF = 1'b0;
    logic [DATA_W-1:0] srcData;
    logic              srcValid, srcSop, srcEop;
    logic              srcReady = 1'b1;
    logic [CNT_W-1:0]  frameWidth, frameHeight;
    logic              frameField, frameStatValid, overflowFlag;
    logic              overflowClr = 1'b0;

    typedef struct packed {
        logic              eop;
        logic              sop;
        logic [DATA_W-1:0] data;
    } beat_t;

    beat_t expQ[$];
    beat_t monBeat;
    beat_t prevBeat;
    logic  prevStalled = 1'b0;
    logic  randomReady = 1'b0;
    int    testsRun = 0, testsFailed = 0;
    int    statPulses = 0, sopSeen = 0, eopSeen = 0;

    cvi_stream_rx #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .vid_clk_clk       (clk),
        .vid_reset_reset_n (rstN),
        .vid_data          (vidData),
        .vid_datavalid     (vidDv),
        .vid_h_sync        (vidHs),
        .vid_v_sync        (vidVs),
        .vid_f             (vidF),
        .src_data          (srcData),
        .src_valid         (srcValid),
        .src_ready         (srcReady),
        .src_startofpacket (srcSop),
        .src_endofpacket   (srcEop),
        .frame_width       (frameWidth),
        .frame_height      (frameHeight),
        .frame_field       (frameField),
        .frame_stat_valid  (frameStatValid),
        .overflow          (overflowFlag),
        .overflow_clr      (overflowClr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic dv, input logic hs, input logic vs, input logic f,
                                 input logic [DATA_W-1:0] d);
        vidDv   = dv;
        vidHs   = hs;
        vidVs   = vs;
        vidF    = f;
        vidData = d;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic hsPulse();
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
        idle(1);
    endtask

    task automatic vsPulse();
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);
        idle(1);
    endtask

    // Sends one frame into an already-opened frame period and closes it with a VS edge.
    task automatic sendFrame(input int w, input int h, input logic [DATA_W-1:0] base,
                             input logic f, input int gap);
        beat_t b;
        for (int l = 0; l < h; l++) begin
            for (int p = 0; p < w; p++) begin
                b.data = base + DATA_W'(l * w + p);
                b.sop  = (l == 0) && (p == 0);
                b.eop  = (l == h - 1) && (p == w - 1);
                expQ.push_back(b);
                applyStimulus(1'b1, 1'b0, 1'b0, f, b.data);
                idle(gap);
            end
            if (l < h - 1) hsPulse();
        end
        vsPulse();
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while (expQ.size() != 0 && n < 1000) begin
            tick();
            n++;
        end
        repeat (4) tick();
        checkOutput(tag, 64'(expQ.size()), 64'(0));
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_valid"},  64'(srcValid), 64'(0));
        checkOutput({tag, "_data"},   64'(srcData), 64'(0));
        checkOutput({tag, "_sop"},    64'(srcSop), 64'(0));
        checkOutput({tag, "_eop"},    64'(srcEop), 64'(0));
        checkOutput({tag, "_width"},  64'(frameWidth), 64'(0));
        checkOutput({tag, "_height"}, 64'(frameHeight), 64'(0));
        checkOutput({tag, "_field"},  64'(frameField), 64'(0));
        checkOutput({tag, "_statv"},  64'(frameStatValid), 64'(0));
        checkOutput({tag, "_ovf"},    64'(overflowFlag), 64'(0));
    endtask

    // Output monitor: pops the scoreboard on each handshake and checks hold-while-stalled.
    always @(negedge clk) begin
        if (rstN) begin
            if (prevStalled)
                checkOutput("stall_hold", 64'({srcValid, srcEop, srcSop, srcData}), 64'({1'b1, prevBeat}));
            if (srcValid && srcReady) begin
                checkOutput("beat_expected", 64'(expQ.size() != 0), 64'(1));
                if (expQ.size() != 0) begin
                    monBeat = expQ.pop_front();
                    checkOutput("beat", 64'({srcEop, srcSop, srcData}), 64'(monBeat));
                end
                if (srcSop) sopSeen++;
                if (srcEop) eopSeen++;
            end
            prevStalled = srcValid && !srcReady;
            prevBeat    = {srcEop, srcSop, srcData};
            if (frameStatValid) statPulses++;
        end else begin
            prevStalled = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (randomReady) srcReady = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int pulses0, sop0, eop0;
        beat_t b;

        repeat (3) tick();
        checkReset("reset");
        rstN = 1'b1;

        // Tail of a frame already in flight at reset release must be ignored.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_0000 + DATA_W'(i));
        idle(2);
        vsPulse();

        sendFrame(4, 2, 32'h0001_0000, 1'b0, 0);
        waitDrain("f4x2_drain");
        checkOutput("f4x2_pulses", 64'(statPulses), 64'(1));
        checkOutput("f4x2_width",  64'(frameWidth), 64'(4));
        checkOutput("f4x2_height", 64'(frameHeight), 64'(2));
        checkOutput("f4x2_field",  64'(frameField), 64'(0));
        checkOutput("f4x2_ovf",    64'(overflowFlag), 64'(0));

        sendFrame(1, 1, 32'h0002_0000, 1'b1, 0);
        waitDrain("f1x1_drain");
        checkOutput("f1x1_pulses", 64'(statPulses), 64'(2));
        checkOutput("f1x1_width",  64'(frameWidth), 64'(1));
        checkOutput("f1x1_height", 64'(frameHeight), 64'(1));
        checkOutput("f1x1_field",  64'(frameField), 64'(1));

        // Stalled sink: only DEPTH-1 entries survive, the last one closing the packet.
        srcReady = 1'b0;
        idle(1);
        pulses0 = statPulses;
        for (int i = 0; i < 40; i++) begin
            if (i < DEPTH - 1) begin
                b.data = 32'h0003_0000 + DATA_W'(i);
                b.sop  = (i == 0);
                b.eop  = (i == DEPTH - 2);
                expQ.push_back(b);
            end
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0003_0000 + DATA_W'(i));
        end
        vsPulse();
        idle(4);
        checkOutput("ovf_set",      64'(overflowFlag), 64'(1));
        checkOutput("ovf_no_stats", 64'(statPulses), 64'(pulses0));
        checkOutput("ovf_valid",    64'(srcValid), 64'(1));
        srcReady = 1'b1;
        waitDrain("ovf_drain");
        sendFrame(3, 3, 32'h0004_0000, 1'b0, 0);
        waitDrain("f3x3_drain");
        checkOutput("f3x3_pulses", 64'(statPulses), 64'(pulses0 + 1));
        checkOutput("f3x3_width",  64'(frameWidth), 64'(3));
        checkOutput("f3x3_height", 64'(frameHeight), 64'(3));
        checkOutput("ovf_sticky",  64'(overflowFlag), 64'(1));
        overflowClr = 1'b1;
        tick();
        overflowClr = 1'b0;
        checkOutput("ovf_clr", 64'(overflowFlag), 64'(0));

        // Random backpressure with blanking between pixels.
        sop0 = sopSeen;
        eop0 = eopSeen;
        randomReady = 1'b1;
        sendFrame(16, 4, 32'h0005_0000, 1'b0, 3);
        randomReady = 1'b0;
        srcReady = 1'b1;
        waitDrain("f16x4_drain");
        checkOutput("f16x4_sops",   64'(sopSeen - sop0), 64'(1));
        checkOutput("f16x4_eops",   64'(eopSeen - eop0), 64'(1));
        checkOutput("f16x4_width",  64'(frameWidth), 64'(16));
        checkOutput("f16x4_height", 64'(frameHeight), 64'(4));
        checkOutput("f16x4_ovf",    64'(overflowFlag), 64'(0));

        // Reset mid-frame: everything vanishes at once, no partial EOP afterwards.
        srcReady = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0006_0000 + DATA_W'(i));
        rstN = 1'b0;
        #1;
        checkReset("midrst");
        idle(3);
        rstN = 1'b1;
        srcReady = 1'b1;
        eop0 = eopSeen;
        for (int i = 3; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0006_0000 + DATA_W'(i));
        idle(2);
        vsPulse();
        idle(6);
        checkOutput("midrst_no_eop", 64'(eopSeen), 64'(eop0));
        sendFrame(2, 2, 32'h0007_0000, 1'b0, 0);
        waitDrain("f2x2_drain");
        checkOutput("f2x2_eop",    64'(eopSeen - eop0), 64'(1));
        checkOutput("f2x2_width",  64'(frameWidth), 64'(2));
        checkOutput("f2x2_height", 64'(frameHeight), 64'(2));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
